prio_arbiter_n: RTL and testbench

//  N-input registered flit arbiter for the MinBD router. It supersedes the
//  2-input combinational label arbiter.
//  - Picks one winning flit label per cycle.
//  - Priority order: valid > gold > silver > lowest flit_id > round-robin.
//    The round-robin step replaces the random tie-break.
//  - Holds the result in a valid/ready output register.
//  - Owns the golden-epoch counter that sets which packet ID is gold.

---
 rtl/prio_arbiter_n.sv | 87 ++++++++
 tb/tb_prio_arbiter_n.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/prio_arbiter_n.sv
`ifndef WIDTH_PKTSZ
`define WIDTH_PKTSZ 4
`endif
// prio_arbiter_n: registered N-input flit arbiter (valid > gold > silver > oldest flit_id > round-robin)
// that also owns the golden-epoch counter selecting the gold packet ID.
module prio_arbiter_n #(
    parameter int NUM_IN      = 4,
    parameter int WIDTH_LABEL = 2,
    parameter int WIDTH_PKTSZ = `WIDTH_PKTSZ,
    parameter int WIDTH_GOLD  = 8,
    parameter int EPOCH_LEN   = 64,
    localparam int IW = $clog2(NUM_IN),
    localparam int EW = $clog2(EPOCH_LEN)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_IN-1:0]             vld,
    input  logic [NUM_IN-1:0]             gold,
    input  logic [NUM_IN-1:0]             silver,
    input  logic [NUM_IN*WIDTH_PKTSZ-1:0] flit_id,
    input  logic [NUM_IN*WIDTH_LABEL-1:0] label,
    output logic [NUM_IN-1:0]             grant,
    output logic                          out_vld,
    input  logic                          out_rdy,
    output logic [WIDTH_LABEL-1:0]        label_win,
    output logic [IW-1:0]                 idx_win,
    output logic [WIDTH_GOLD-1:0]         gold_id,
    output logic                          epoch_tick
);
    logic [NUM_IN-1:0] c1, c2, c3;
    logic [WIDTH_PKTSZ-1:0] min_id;
    logic [IW-1:0] win, cand, rr_ptr;
    logic [IW:0] idx;
    logic [EW-1:0] epoch_cnt;
    logic found, accept, any, last;
    always_comb begin
        c1 = |(vld & gold) ? vld & gold : vld;
        c2 = |(c1 & silver) ? c1 & silver : c1;
        min_id = '1;
        for (int i = 0; i < NUM_IN; i++)
            if (c2[i] && flit_id[i*WIDTH_PKTSZ +: WIDTH_PKTSZ] < min_id)
                min_id = flit_id[i*WIDTH_PKTSZ +: WIDTH_PKTSZ];
        for (int i = 0; i < NUM_IN; i++)
            c3[i] = c2[i] && flit_id[i*WIDTH_PKTSZ +: WIDTH_PKTSZ] == min_id;
        win = '0;
        found = 1'b0;
        idx = '0;
        cand = '0;
        // scan from rr_ptr upward, wrapping without a modulo operator
        for (int k = 0; k < NUM_IN; k++) begin
            idx = {1'b0, rr_ptr} + (IW+1)'(k);
            idx = idx >= (IW+1)'(NUM_IN) ? idx - (IW+1)'(NUM_IN) : idx;
            cand = idx[IW-1:0];
            if (!found && c3[cand]) begin
                win = cand;
                found = 1'b1;
            end
        end
    end
    assign accept = ~out_vld | out_rdy;
    assign any = |vld;
    assign last = epoch_cnt == EW'(EPOCH_LEN - 1);
    assign grant = (!reset && accept && any) ? NUM_IN'(1) << win : '0;
    always_ff @(posedge clk) begin
        if (reset) begin
            out_vld    <= 1'b0;
            label_win  <= '0;
            idx_win    <= '0;
            rr_ptr     <= '0;
            epoch_cnt  <= '0;
            gold_id    <= '0;
            epoch_tick <= 1'b0;
        end else begin
            epoch_cnt  <= last ? '0 : epoch_cnt + 1'b1;
            gold_id    <= gold_id + WIDTH_GOLD'(last);
            epoch_tick <= last;
            if (accept) begin
                out_vld <= any;
                if (any) begin
                    label_win <= label[win*WIDTH_LABEL +: WIDTH_LABEL];
                    idx_win   <= win;
                    rr_ptr    <= win == IW'(NUM_IN - 1) ? '0 : win + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_prio_arbiter_n.sv
// tb_prio_arbiter_n: directed checks of priority tiers, round-robin, handshake stall,
// golden-epoch rollover and reset behaviour.
module tb_prio_arbiter_n;
    localparam int N = 4, WL = 2, WP = 4, WG = 8, EL = 64;
    logic clk = 1'b0, reset = 1'b1, out_rdy = 1'b1;
    logic [N-1:0] vld = '0, gold = '0, silver = '0, grant;
    logic [N*WP-1:0] flit_id = '0;
    logic [N*WL-1:0] label = '0;
    logic out_vld, epoch_tick;
    logic [WL-1:0] label_win;
    logic [1:0] idx_win;
    logic [WG-1:0] gold_id;
    int tests = 0, fails = 0, n = 0;
    logic [3:0] exp_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    prio_arbiter_n #(.NUM_IN(N), .WIDTH_LABEL(WL), .WIDTH_PKTSZ(WP),
                     .WIDTH_GOLD(WG), .EPOCH_LEN(EL)) dut (
        .clk(clk), .reset(reset), .vld(vld), .gold(gold), .silver(silver),
        .flit_id(flit_id), .label(label), .grant(grant), .out_vld(out_vld),
        .out_rdy(out_rdy), .label_win(label_win), .idx_win(idx_win),
        .gold_id(gold_id), .epoch_tick(epoch_tick));

    always #5 clk = ~clk;
    always @(posedge clk) n <= reset ? 0 : n + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vld = 4'b1111;
        #1 chk("grant_in_reset", 32'(grant), 0);
        repeat (3) step();
        vld = '0;
        reset = 1'b0;
        #1;
        chk("rst_out_vld", 32'(out_vld), 0);
        chk("rst_idx", 32'(idx_win), 0);
        chk("rst_label", 32'(label_win), 0);
        chk("rst_gold_id", 32'(gold_id), 0);
        chk("rst_tick", 32'(epoch_tick), 0);
        chk("idle_grant", 32'(grant), 0);
        step();
        chk("idle_out_vld", 32'(out_vld), 0);
        while (n < EL - 1) step();
        chk("tick_before", 32'(epoch_tick), 0);
        chk("gold_before", 32'(gold_id), 0);
        step();
        chk("tick_pulse", 32'(epoch_tick), 1);
        chk("gold_after", 32'(gold_id), 1);
        step();
        chk("tick_drop", 32'(epoch_tick), 0);

        vld = 4'b1111; gold = 4'b0100; silver = 4'b0011;
        label = {2'd0, 2'd1, 2'd3, 2'd2};
        #1 chk("gold_grant", 32'(grant), 32'b0100);
        step();
        chk("gold_out_vld", 32'(out_vld), 1);
        chk("gold_idx", 32'(idx_win), 2);
        chk("gold_label", 32'(label_win), 1);

        vld = 4'b1010; gold = '0; silver = '0;
        flit_id = {4'd1, 4'd0, 4'd3, 4'd0};
        #1 chk("age_grant", 32'(grant), 32'b1000);
        step();
        chk("age_idx", 32'(idx_win), 3);
        chk("age_label", 32'(label_win), 0);

        vld = 4'b0111; gold = 4'b1000; silver = 4'b0110;
        flit_id = {4'd0, 4'd2, 4'd5, 4'd0};
        #1 chk("silver_grant", 32'(grant), 32'b0100);
        step();
        chk("silver_idx", 32'(idx_win), 2);

        vld = 4'b1000; gold = '0; silver = '0;
        #1 chk("wrap_grant", 32'(grant), 32'b1000);
        step();
        chk("wrap_idx", 32'(idx_win), 3);

        vld = 4'b1111; flit_id = '0;
        for (int i = 0; i < 5; i++) begin
            #1 chk("rr_grant", 32'(grant), 32'(exp_g[i]));
            step();
            chk("rr_idx", 32'(idx_win), 32'(i % N));
            chk("rr_out_vld", 32'(out_vld), 1);
        end

        out_rdy = 1'b0; vld = 4'b0001;
        label = {2'd0, 2'd1, 2'd3, 2'd1};
        for (int i = 0; i < 3; i++) begin
            #1 chk("stall_grant", 32'(grant), 0);
            step();
            chk("stall_label", 32'(label_win), 2);
            chk("stall_out_vld", 32'(out_vld), 1);
        end
        out_rdy = 1'b1;
        #1 chk("release_grant", 32'(grant), 32'b0001);
        step();
        chk("release_label", 32'(label_win), 1);
        chk("release_idx", 32'(idx_win), 0);

        vld = '0;
        #1 chk("drain_grant", 32'(grant), 0);
        step();
        chk("drain_out_vld", 32'(out_vld), 0);
        chk("drain_label_hold", 32'(label_win), 1);

        while (n < 256 * EL - 1) step();
        chk("gold_255", 32'(gold_id), 255);
        step();
        chk("gold_wrap", 32'(gold_id), 0);
        chk("gold_wrap_tick", 32'(epoch_tick), 1);

        vld = 4'b0001; flit_id = '0;
        step();
        chk("pre_rst_out_vld", 32'(out_vld), 1);
        reset = 1'b1; vld = 4'b1111;
        #1 chk("rst_hold_grant", 32'(grant), 0);
        step();
        chk("midrst_out_vld", 32'(out_vld), 0);
        chk("midrst_gold", 32'(gold_id), 0);
        reset = 1'b0;
        #1 chk("midrst_rr_grant", 32'(grant), 32'b0001);
        step();
        chk("midrst_idx", 32'(idx_win), 0);
        chk("midrst_out_vld2", 32'(out_vld), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
